// File: rtl/common.sv
// Shared definitions for the IM2 interrupt controller slice.
//   reti_state_t : states of the RETI opcode-fetch tracker
//   OPC_ED       : first byte of the ED-prefixed RETI instruction
//   OPC_RETI     : second byte of RETI (ED 4D)
//   cpu_bus_t    : snapshot of the shared CPU bus signals this block watches.
//                  Strobes are active-high.
package common;

    typedef enum logic {RETI_IDLE, RETI_ED} reti_state_t;

    localparam logic [7:0] OPC_ED   = 8'hED;
    localparam logic [7:0] OPC_RETI = 8'h4D;

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
        logic        mreq;
        logic        iorq;
        logic        rd;
        logic        m1;
    } cpu_bus_t;

endpackage

// File: rtl/reti_decoder.sv
// RETI opcode-fetch tracker.
// Watches opcode fetches (m1 & mreq & rd) on the CPU bus, keeps the last data
// byte sampled during each fetch, and evaluates it when the fetch ends. The
// sequence ED,4D produces a one-cycle reti pulse; repeated ED prefixes keep
// the tracker armed.
// Ports:
//   clk28, rst_n : clock, asynchronous active-low reset
//   bus          : CPU bus snapshot (uses d, mreq, rd, m1)
//   clear        : forces the tracker back to IDLE (interrupt acknowledge)
//   reti         : one-cycle pulse on the clk28 edge that sees the 4D fetch end
//   state        : current tracker state, for debug
module reti_decoder
    import common::*;
(
    input  logic        clk28,
    input  logic        rst_n,
    input  cpu_bus_t    bus,
    input  logic        clear,
    output logic        reti,
    output reti_state_t state
);

    logic        fetch;
    logic        fetch_q;
    logic        fetch_end;
    logic [7:0]  opc;
    reti_state_t state_nxt;

    assign fetch     = bus.m1 & bus.mreq & bus.rd;
    assign fetch_end = fetch_q & ~fetch;

    // Address and iorq are not needed to recognise an opcode fetch.
    logic unused_bus;
    assign unused_bus = ^{bus.a, bus.iorq};

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            fetch_q <= 1'b0;
            opc     <= 8'h00;
            state   <= RETI_IDLE;
        end else begin
            fetch_q <= fetch;
            // Keep re-sampling while the fetch is active; the value held when
            // the fetch ends is the settled opcode.
            if (fetch) opc <= bus.d;
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        reti      = 1'b0;
        if (clear) begin
            state_nxt = RETI_IDLE;
        end else if (fetch_end) begin
            case (state)
                RETI_IDLE: begin
                    if (opc == OPC_ED) state_nxt = RETI_ED;
                end
                RETI_ED: begin
                    if (opc == OPC_RETI) begin
                        reti      = 1'b1;
                        state_nxt = RETI_IDLE;
                    end else if (opc == OPC_ED) begin
                        state_nxt = RETI_ED;
                    end else begin
                        state_nxt = RETI_IDLE;
                    end
                end
                default: state_nxt = RETI_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/im2_intctl.sv
// Z80 mode-2 interrupt controller (responder side).
// Captures edge-triggered requests from up to four peripherals, raises a
// level request toward the CPU, answers the interrupt-acknowledge cycle with
// an even IM2 vector, and retires the in-service level on RETI.
// Ports:
//   clk28, rst_n  : clock, asynchronous active-low reset
//   bus           : CPU bus snapshot (m1, iorq for ack; fetch signals for RETI)
//   irq           : asynchronous request lines, rising edge requests service
//   irq_en        : per-source enable; low clears the pending request
//   vector_base   : bits [7:3] form the top of the vector
//   int_req       : registered request toward the CPU INT line
//   d_out         : vector byte
//   d_out_active  : this block owns the data bus for the current ack
//   in_service    : in-service flags
// Handshake: an acknowledge is m1 & iorq sampled high on clk28. The edge that
// first sees it selects the winner; d_out_active then stays high until the
// edge that sees the acknowledge gone.
module im2_intctl
    import common::*;
#(
    parameter int NSRC = 4
) (
    input  logic            clk28,
    input  logic            rst_n,
    input  cpu_bus_t        bus,
    input  logic [NSRC-1:0] irq,
    input  logic [NSRC-1:0] irq_en,
    input  logic [7:0]      vector_base,
    output logic            int_req,
    output logic [7:0]      d_out,
    output logic            d_out_active,
    output logic [NSRC-1:0] in_service
);

    logic [NSRC-1:0] irq_s1, irq_s2, irq_q;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] pending;
    logic [NSRC-1:0] below_top;
    logic [NSRC-1:0] elig_req;
    logic [NSRC-1:0] elig_ack;
    logic [NSRC-1:0] ack_onehot;
    logic [NSRC-1:0] is_lowest;
    logic [1:0]      ack_idx;
    logic            ack_hit;
    logic            ack_take;
    logic            intack, intack_q, intack_rise;
    logic            owned;
    logic [7:0]      vec;
    logic            reti;
    reti_state_t     reti_state;

    assign rise        = irq_s2 & ~irq_q;
    assign intack      = bus.m1 & bus.iorq;
    assign intack_rise = intack & ~intack_q;
    assign ack_take    = intack_rise & ack_hit;

    logic unused_ok;
    assign unused_ok = ^{vector_base[2:0], reti_state};

    always_comb begin
        logic blocked;
        blocked   = 1'b0;
        below_top = '0;
        // A source is eligible only if no in-service level at or above its
        // own priority (index <= i) is active.
        for (int i = 0; i < NSRC; i++) begin
            blocked      = blocked | in_service[i];
            below_top[i] = ~blocked;
        end
        elig_req = pending & below_top;
        // Ack selection honours a same-cycle enable drop: the clear wins.
        elig_ack = pending & irq_en & below_top;
        ack_hit  = |elig_ack;
        // Isolate the lowest set bit (highest priority).
        ack_onehot = elig_ack & (~elig_ack + NSRC'(1));
        is_lowest  = in_service & (~in_service + NSRC'(1));
        ack_idx    = 2'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (elig_ack[i]) ack_idx = 2'(i);
        end
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            irq_s1     <= '0;
            irq_s2     <= '0;
            irq_q      <= '0;
            pending    <= '0;
            in_service <= '0;
            int_req    <= 1'b0;
            intack_q   <= 1'b0;
            owned      <= 1'b0;
            vec        <= 8'h00;
        end else begin
            irq_s1   <= irq;
            irq_s2   <= irq_s1;
            irq_q    <= irq_s2;
            intack_q <= intack;
            int_req  <= |elig_req;
            // A new edge on the source being acknowledged re-queues it.
            pending  <= ((pending & ~(ack_take ? ack_onehot : '0)) | rise) & irq_en;
            in_service <= (in_service & ~(reti ? is_lowest : '0))
                        | (ack_take ? ack_onehot : '0);
            if (intack_rise) begin
                owned <= ack_hit;
                if (ack_hit) vec <= {vector_base[7:3], ack_idx, 1'b0};
            end else if (!intack) begin
                owned <= 1'b0;
            end
        end
    end

    assign d_out        = vec;
    assign d_out_active = owned;

    reti_decoder u_reti (
        .clk28 (clk28),
        .rst_n (rst_n),
        .bus   (bus),
        .clear (intack_rise),
        .reti  (reti),
        .state (reti_state)
    );

endmodule
